// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if
//   SPI slave front-end. Deserialises 10-bit {cmd[1:0], payload[7:0]} frames
//   from mosi (MSB first) into rx_data with a one-cycle rx_valid pulse, and
//   serialises one 8-bit read byte onto miso during a read-data frame.
//   The SPI bit clock is the system clock: one bit per rising clk edge.
//
// Optional feature macro: SPI_BUSY_OUT_EN
//   defined   -> adds registered output busy, high whenever state != IDLE.
//   undefined -> busy port and logic absent.
//
// Ports
//   clk       in   system / SPI bit clock (rising edge)
//   rst       in   synchronous reset, active-high
//   mosi      in   serial data from master, MSB first
//   ss_n      in   slave select, active-low; high ends or aborts a frame
//   tx_data   in   read byte returned to master
//   tx_valid  in   tx_data valid; starts miso shifting in the read-data wait
//   miso      out  serial data to master, MSB first; 0 when not shifting
//   rx_data   out  last complete frame, [9:8] = cmd, [7:0] = payload
//   rx_valid  out  one-cycle pulse when rx_data updates
//   busy      out  (SPI_BUSY_OUT_EN only) state != IDLE
// -----------------------------------------------------------------------------
module spi_slave_if #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mosi,
  input  logic              ss_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              miso,
  output logic [FRAME_W-1:0] rx_data,
  output logic              rx_valid
`ifdef SPI_BUSY_OUT_EN
  ,
  output logic              busy
`endif
);

  localparam int BCW = $clog2(FRAME_W + 1);
  localparam int TCW = $clog2(DATA_W + 2);

  localparam logic [BCW-1:0] FRAME_LAST = BCW'(FRAME_W - 1);
  localparam logic [BCW-1:0] FRAME_FULL = BCW'(FRAME_W);
  localparam logic [TCW-1:0] TX_LAST    = TCW'(DATA_W);
  localparam logic [TCW-1:0] TX_DONE    = TCW'(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rd_addr_seen_q, rd_addr_seen_d;
  logic [DATA_W-1:0]    tx_shift_q, tx_shift_d;
  // 0: waiting for tx_valid, 1..DATA_W: shifting, DATA_W+1: finished
  logic [TCW-1:0]       tx_cnt_q, tx_cnt_d;
  logic                 miso_q, miso_d;
  logic [FRAME_W-1:0]   shift_in;

  assign shift_in = {shift_q[FRAME_W-2:0], mosi};

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    tx_shift_d     = tx_shift_q;
    tx_cnt_d       = tx_cnt_q;
    miso_d         = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        tx_cnt_d  = '0;
        // The selecting edge carries a preamble bit that is discarded.
        if (!ss_n) state_d = CHK_CMD;
      end

      CHK_CMD: begin
        if (ss_n) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else begin
          shift_d   = shift_in;
          bit_cnt_d = BCW'(1);
          if (!mosi)               state_d = WRITE;
          else if (rd_addr_seen_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end
      end

      WRITE, READ_ADD, READ_DATA: begin
        if (ss_n) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          tx_cnt_d  = '0;
          // Deselect on the edge right after the last miso bit still counts
          // as a finished read.
          if (state_q == READ_DATA && tx_cnt_q == TX_LAST) rd_addr_seen_d = 1'b0;
        end else if (bit_cnt_q != FRAME_FULL) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == FRAME_LAST) begin
            rx_data_d  = shift_in;
            rx_valid_d = 1'b1;
            if (state_q == READ_ADD) rd_addr_seen_d = 1'b1;
          end
        end else if (state_q == READ_DATA) begin
          if (tx_cnt_q == '0) begin
            if (tx_valid) begin
              tx_shift_d = tx_data;
              miso_d     = tx_data[DATA_W-1];
              tx_cnt_d   = TCW'(1);
            end
          end else if (tx_cnt_q < TX_LAST) begin
            miso_d     = tx_shift_q[DATA_W-2];
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
            tx_cnt_d   = tx_cnt_q + 1'b1;
          end else if (tx_cnt_q == TX_LAST) begin
            rd_addr_seen_d = 1'b0;
            tx_cnt_d       = TX_DONE;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        tx_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    shift_q    <= shift_d;
    tx_shift_q <= tx_shift_d;
    if (rst) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      tx_cnt_q       <= '0;
      miso_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      tx_cnt_q       <= tx_cnt_d;
      miso_q         <= miso_d;
    end
  end

  assign miso     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

`ifdef SPI_BUSY_OUT_EN
  logic busy_q;

  always_ff @(posedge clk) begin
    if (rst) busy_q <= 1'b0;
    else     busy_q <= (state_d != IDLE);
  end

  assign busy = busy_q;
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_if
//   Self-checking bench for spi_slave_if. Inputs change at the falling edge
//   and outputs are checked at the falling edge. The reference model tracks
//   the last complete frame and whether a read address has been seen, and
//   derives the expected miso stream from the frame sequence.
// -----------------------------------------------------------------------------
module tb_spi_slave_if;

  logic       clk;
  logic       rst;
  logic       mosi;
  logic       ss_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
`ifdef SPI_BUSY_OUT_EN
  logic       busy;
`endif

  int total;
  int bad;

  // reference model state
  logic [9:0] exp_rx;
  bit         rd_seen;

  spi_slave_if dut (
    .clk      (clk),
    .rst      (rst),
    .mosi     (mosi),
    .ss_n     (ss_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .miso     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
`ifdef SPI_BUSY_OUT_EN
    ,
    .busy     (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction from IDLE back to IDLE.
  // rx_abort: -1 none, else deselect before frame bit index rx_abort.
  // tx_abort: -1 none, else deselect after miso bit index tx_abort is shown.
  task automatic do_frame(input logic [9:0] f, input logic pre, input logic [7:0] byt,
                          input int rx_abort, input int tx_abort, input int wait_cyc);
    bit is_rd;
    is_rd = f[9] && rd_seen;
    ss_n = 1'b0; mosi = pre; tx_valid = 1'b0;
    tick();
    chk("pre_vld", rx_valid, 0);
    for (int i = 0; i < 10; i++) begin
      if (i == rx_abort) begin
        ss_n = 1'b1; tx_valid = 1'b0;
        tick();
        chk("abort_vld", rx_valid, 0);
        chk("abort_rx", rx_data, exp_rx);
        chk("abort_miso", miso, 0);
        return;
      end
      mosi = f[9-i];
      tx_valid = 1'($urandom);
      tx_data = 8'($urandom);
      tick();
      chk("bit_vld", rx_valid, (i == 9) ? 1 : 0);
      chk("bit_miso", miso, 0);
    end
    tx_valid = 1'b0;
    exp_rx = f;
    chk("rx_data", rx_data, exp_rx);
    if (f[9] && !is_rd) rd_seen = 1'b1;
    for (int w = 0; w < wait_cyc; w++) begin
      mosi = 1'($urandom);
      tick();
      chk("wait_vld", rx_valid, 0);
      chk("wait_miso", miso, 0);
    end
    tx_valid = 1'b1; tx_data = byt;
    tick();
    tx_valid = 1'b0; tx_data = ~byt;
    for (int j = 0; j < 8; j++) begin
      chk("miso_bit", miso, is_rd ? byt[7-j] : 1'b0);
      if (j == tx_abort) begin
        ss_n = 1'b1;
        tick();
        chk("txab_miso", miso, 0);
        chk("txab_vld", rx_valid, 0);
        if (is_rd && j == 7) rd_seen = 1'b0;
        return;
      end
      tick();
    end
    chk("miso_end", miso, 0);
    if (is_rd) rd_seen = 1'b0;
    ss_n = 1'b1;
    tick();
    chk("end_miso", miso, 0);
    chk("end_vld", rx_valid, 0);
    chk("end_rx", rx_data, exp_rx);
  endtask

  initial begin
    total = 0; bad = 0;
    exp_rx = '0; rd_seen = 1'b0;
    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    @(negedge clk);
    tick();
    chk("rst_miso", miso, 0);
    chk("rst_rx", rx_data, 0);
    chk("rst_vld", rx_valid, 0);
`ifdef SPI_BUSY_OUT_EN
    chk("rst_busy", busy, 0);
`endif
    rst = 1'b0;
    tick();

    // directed cases
    do_frame(10'b0000000101, 1'b0, 8'h5A, -1, -1, 2);  // write address
    do_frame(10'b0110100011, 1'b0, 8'h5A, -1, -1, 0);  // write data
    do_frame(10'b1000000101, 1'b1, 8'h11, -1, -1, 1);  // read address
    do_frame(10'b1100000000, 1'b0, 8'hA3, -1, -1, 0);  // read data -> miso A3
    do_frame(10'b0101010101, 1'b0, 8'h00, 5, -1, 0);   // abort after 5 bits
    do_frame(10'b0000000011, 1'b0, 8'h00, -1, -1, 0);  // 0x003
    do_frame(10'b1011110000, 1'b0, 8'h00, -1, -1, 0);  // read address
    do_frame(10'b1100001111, 1'b1, 8'hC6, -1, 3, 2);   // read data aborted mid-shift
    do_frame(10'b1100000001, 1'b0, 8'h96, -1, -1, 0);  // still read data

    // reset during read-data shifting
    do_frame(10'b1000000001, 1'b0, 8'h00, -1, -1, 0);
    ss_n = 1'b0; mosi = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      mosi = (10'h3C5 >> (9 - i)) & 1;
      tick();
    end
    tx_valid = 1'b1; tx_data = 8'hFF;
    tick();
    tx_valid = 1'b0;
    chk("pre_rst_miso", miso, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_rx = '0; rd_seen = 1'b0;
    chk("mrst_miso", miso, 0);
    chk("mrst_rx", rx_data, 0);
    chk("mrst_vld", rx_valid, 0);
    ss_n = 1'b1;
    tick();
    do_frame(10'b1100000110, 1'b0, 8'hFF, -1, -1, 0);  // now a read address
    do_frame(10'b1100000111, 1'b0, 8'h3C, -1, -1, 0);  // read data

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      do_frame(10'($urandom), 1'($urandom), 8'($urandom),
               ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : -1,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
               int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
